mixer_n: RTL
============

Name: mixer_n

Overview:
- Parametrised, time-multiplexed successor to the fixed 4-input combinational mixer.
- Mixes NCH signed oscillator voices, each with its own volume and enable, into one saturated BITDEPTH sample.
- On each sample_tick it snapshots its inputs, then runs one multiply-accumulate per clk, so the whole mix uses a single multiplier.
- Sits between the oscillator bank and the output stage (PDM/DAC), in the clk domain. sample_tick comes from the sample clock divider as a 1-clk pulse.

Parameters:
- NCH, 4: number of input channels (≥1).
- BITDEPTH, 14: sample width of inputs and output, signed two's complement.
- VOLBITS, 8: per-channel volume width, unsigned. Gain = vol / 2^VOLBITS.

Ports:
- clk  in  1: system clock (8 MHz).
- rst  in  1: synchronous, active-high reset.
- sample_tick  in  1: start-of-mix strobe, one clk wide.
- in_flat  in  NCH*BITDEPTH: channel i at [i*BITDEPTH +: BITDEPTH], signed.
- vol_flat  in  NCH*VOLBITS: channel i at [i*VOLBITS +: VOLBITS], unsigned.
- ch_enable  in  NCH: 1 = channel contributes; 0 = muted.
- mix  out  BITDEPTH: signed mixed sample, held between updates.
- mix_valid  out  1: 1-clk pulse when mix updates.
- busy  out  1: high from the first clk after an accepted tick until mix_valid.
- clip  out  1: 1-clk pulse, coincident with mix_valid, when saturation occurred.
- overrun  out  1: 1-clk pulse when a tick arrives while busy.

Behaviour:
- Reset values: mix=0, mix_valid=0, busy=0, clip=0, overrun=0. State=IDLE, accumulator=0, channel index=0.
- Internal widths:
  - Accumulator is signed, ACCW = BITDEPTH+VOLBITS+clog2(NCH)+1. No internal overflow is possible.
  - Product = signed(in_i) * signed({1'b0, vol_i}), BITDEPTH+VOLBITS+1 bits.
- IDLE:
  - On sample_tick, snapshot in_flat, vol_flat and ch_enable into internal registers.
  - Clear accumulator, set idx=0, go to ACC.
  - Inputs may change freely after the tick.
- ACC (exactly NCH cycles):
  - Each cycle, if en[idx] then acc += in[idx]*vol[idx]; otherwise acc is unchanged.
  - idx increments each cycle. After idx = NCH-1, go to OUT.
- OUT (1 cycle):
  - s = acc >>> VOLBITS (arithmetic shift, floor), applied once to the total sum.
  - Saturate s to [-2^(BITDEPTH-1), 2^(BITDEPTH-1)-1].
  - Register the result into mix, pulse mix_valid, pulse clip if s was out of range, return to IDLE.
- Latency: tick registered at edge T gives mix_valid high in cycle T+NCH+1. Example: NCH=4 gives T+5.
- sample_tick while busy (ACC or OUT): ignored, overrun pulses, the in-progress mix is unaffected.
- A tick in the same cycle that OUT completes counts as busy and is rejected.
- rst mid-mix: abort immediately, all outputs back to reset values, no mix_valid.
- All ch_enable=0: mix=0, mix_valid still pulses.
- vol=0 gives silence. vol=2^VOLBITS-1 gives gain 255/256; unity gain is not reachable by design.

Optional Feature:
- MIXER_MASTER_VOL_EN defined:
  - Adds port master_vol  in  VOLBITS, snapshotted at tick with the other inputs.
  - Adds state SCALE between ACC and OUT: acc = (acc >>> VOLBITS) * master_vol. OUT then shifts and saturates as normal.
  - Latency becomes T+NCH+2. Saturation is checked only after the master stage.
- Undefined: no master_vol port, no SCALE state, latency T+NCH+1.

Decomposition:
- Package mixer_pkg holds:
  - state enum {IDLE, ACC, SCALE, OUT};
  - the ACCW calculation function;
  - the clog2 helper;
  - the saturate function (signed ACCW-bit in, BITDEPTH-bit out, plus clip flag).
- One natural sub-module: mixer_sat, the combinational saturator with clip flag, reused by the output stage.
- The FSM, index counter and MAC stay in mixer_n.

Test Plan:
- Reset: assert rst 3 clk → mix=0, mix_valid=0, busy=0, clip=0. Tick during rst → no response.
- Nominal (NCH=4): all in=1000, vol=128, en=4'b1111, tick at T → mix=2000 and mix_valid pulse at T+5, clip=0.
- Mask plus floor: in=100/200/300/400, vol=128, en=4'b0101 → mix=200. in=-3 on ch0 only, vol=128 → mix=-2.
- Saturation: all in=8191, vol=255 → mix=8191, clip=1. All in=-8192, vol=255 → mix=-8192, clip=1.
- Overrun and abort:
  - Second tick at T+2 → overrun pulse, single mix_valid at T+5, value unchanged.
  - rst at T+3 → no mix_valid, mix=0; next tick mixes correctly.
- MIXER_MASTER_VOL_EN: all in=1000, vol=128, master_vol=64 → mix=500 at T+6. Without the macro, the nominal test gives T+5.

Source files
------------

// File: rtl/mixer_pkg.sv
// Shared state encoding plus width and saturation helpers for the mixer_n datapath.
// Purely declarative: no latency, no flow control.
package mixer_pkg;

  typedef enum logic [1:0] {IDLE, ACC, SCALE, OUT} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Worst case NCH full-scale products cannot overflow this signed width.
  function automatic int acc_width(input int nch, input int bitdepth, input int volbits);
    return bitdepth + volbits + clog2(nch) + 1;
  endfunction

  // Clamps to the signed bitdepth range; caller truncates the result to bitdepth bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] s,
                                                  input int bitdepth,
                                                  output logic clip);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bitdepth - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    clip = (s > hi) || (s < lo);
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/mixer_sat.sv
// Combinational saturator W_IN -> W_OUT signed with clip flag; zero latency.
// No flow control: output follows input within the cycle.
module mixer_sat
  import mixer_pkg::*;
#(
  parameter int W_IN  = 23,
  parameter int W_OUT = 14
) (
  input  logic signed [W_IN-1:0]  din,
  output logic signed [W_OUT-1:0] dout,
  output logic                    clip
);

  logic signed [63:0] wide_in;

  assign wide_in = 64'(din);

  always_comb begin
    dout = W_OUT'(saturate(wide_in, W_OUT, clip));
  end

endmodule

// File: rtl/mixer_n.sv
// Time-multiplexed NCH-voice mixer, one MAC per clk; mix_valid at T+NCH+1 (T+NCH+2 with MIXER_MASTER_VOL_EN).
// No backpressure: ticks arriving while busy are dropped and flagged on overrun.
module mixer_n
  import mixer_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int BITDEPTH = 14,
  parameter int VOLBITS  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_tick,
  input  logic [NCH*BITDEPTH-1:0]     in_flat,
  input  logic [NCH*VOLBITS-1:0]      vol_flat,
  input  logic [NCH-1:0]              ch_enable,
  output logic signed [BITDEPTH-1:0]  mix,
  output logic                        mix_valid,
  output logic                        busy,
  output logic                        clip,
  output logic                        overrun
`ifdef MIXER_MASTER_VOL_EN
  ,
  input  logic [VOLBITS-1:0]          master_vol
`endif
);

  localparam int ACCW = acc_width(NCH, BITDEPTH, VOLBITS);
  localparam int IDXW = (NCH > 1) ? clog2(NCH) : 1;
  localparam int PW   = BITDEPTH + VOLBITS + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  state_t                      state_q, state_d;
  logic [IDXW-1:0]             idx_q;
  logic signed [ACCW-1:0]      acc_q;
  logic [NCH*BITDEPTH-1:0]     in_q;
  logic [NCH*VOLBITS-1:0]      vol_q;
  logic [NCH-1:0]              en_q;

  logic signed [BITDEPTH-1:0]  cur_in;
  logic [VOLBITS-1:0]          cur_vol;
  logic                        cur_en;
  logic signed [PW-1:0]        prod;
  logic signed [ACCW-1:0]      acc_shr;
  logic signed [BITDEPTH-1:0]  sat_mix;
  logic                        sat_clip;

  assign cur_in  = in_q[int'(idx_q) * BITDEPTH +: BITDEPTH];
  assign cur_vol = vol_q[int'(idx_q) * VOLBITS +: VOLBITS];
  assign cur_en  = en_q[idx_q];
  // Zero-extended volume keeps the product signed without flipping large gains negative.
  assign prod    = PW'(cur_in) * PW'($signed({1'b0, cur_vol}));
  assign acc_shr = acc_q >>> VOLBITS;
  assign busy    = (state_q != IDLE);

`ifdef MIXER_MASTER_VOL_EN
  logic [VOLBITS-1:0]          mvol_q;
  logic signed [ACCW-1:0]      scaled;

  // |acc_shr| <= NCH*2^(BITDEPTH-1) and master < 2^VOLBITS, so the product fits ACCW.
  assign scaled = acc_shr * ACCW'($signed({1'b0, mvol_q}));
`endif

  mixer_sat #(
    .W_IN  (ACCW),
    .W_OUT (BITDEPTH)
  ) u_sat (
    .din  (acc_shr),
    .dout (sat_mix),
    .clip (sat_clip)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (sample_tick) state_d = ACC;
      ACC: begin
        if (idx_q == LAST_IDX) begin
`ifdef MIXER_MASTER_VOL_EN
          state_d = SCALE;
`else
          state_d = OUT;
`endif
        end
      end
      SCALE:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      in_q      <= '0;
      vol_q     <= '0;
      en_q      <= '0;
      mix       <= '0;
      mix_valid <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
`ifdef MIXER_MASTER_VOL_EN
      mvol_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mix_valid <= 1'b0;
      clip      <= 1'b0;
      overrun   <= sample_tick && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            in_q  <= in_flat;
            vol_q <= vol_flat;
            en_q  <= ch_enable;
            acc_q <= '0;
            idx_q <= '0;
`ifdef MIXER_MASTER_VOL_EN
            mvol_q <= master_vol;
`endif
          end
        end
        ACC: begin
          if (cur_en) acc_q <= acc_q + ACCW'(prod);
          idx_q <= idx_q + IDXW'(1);
        end
`ifdef MIXER_MASTER_VOL_EN
        SCALE: acc_q <= scaled;
`endif
        OUT: begin
          mix       <= sat_mix;
          mix_valid <= 1'b1;
          clip      <= sat_clip;
        end
        default: ;
      endcase
    end
  end

endmodule
